// File: rtl/matrix_column_scanner_pkg.sv
// Shared constants and types for the column-scanned LED matrix driver.
package matrix_column_scanner_pkg;

  typedef enum logic {
    S_BLANK,
    S_DWELL
  } scan_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Active-low segment patterns, bit0 = a ... bit6 = g; codes 10-15 are dark.
  localparam logic [6:0] GLYPH_ROM [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

endpackage

// File: rtl/matrix_column_scanner_glyph_lookup.sv
// Combinational glyph code to active-low row pattern decoder.
module glyph_lookup
  import matrix_column_scanner_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  assign pattern = GLYPH_ROM[code];

endmodule

// File: rtl/matrix_column_scanner.sv
// Time-multiplexed column scanner with double-buffered glyph store, enable and blink gating.
module matrix_column_scanner
  import matrix_column_scanner_pkg::*;
#(
  parameter int unsigned COLUMN_SIZE   = 7,
  parameter int unsigned TOTAL_COLUMNS = 4,
  parameter int unsigned DWELL_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES  = 500,
  parameter int unsigned BLINK_FRAMES  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4*TOTAL_COLUMNS-1:0]   frame_data,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic                         enable,
  input  logic                         blink_enable,
  output logic [COLUMN_SIZE-1:0]       row_n,
  output logic [TOTAL_COLUMNS-1:0]     column_n,
  output logic                         frame_start
);

  localparam int unsigned MAX_PHASE = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int unsigned COLW = $clog2(TOTAL_COLUMNS);
  localparam int unsigned FW   = $clog2(2 * BLINK_FRAMES);
  localparam int unsigned GW   = (COLUMN_SIZE < 7) ? COLUMN_SIZE : 7;

  localparam logic [CW-1:0]   DWELL_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]   BLANK_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [COLW-1:0] COL_LAST    = COLW'(TOTAL_COLUMNS - 1);
  localparam logic [FW-1:0]   FRAME_LAST  = FW'(2 * BLINK_FRAMES - 1);
  localparam logic [FW-1:0]   BLINK_START = FW'(BLINK_FRAMES);

  scan_state_t                state;
  logic [CW-1:0]              cnt;
  logic [COLW-1:0]            col;
  logic [FW-1:0]              frame_cnt;
  logic [4*TOTAL_COLUMNS-1:0] active;
  logic [4*TOTAL_COLUMNS-1:0] shadow;
  logic                       pending;

  logic       boundary;
  logic       accept;
  logic       lit;
  logic [3:0] active_code;
  logic [6:0] glyph;

  // Last DWELL cycle of the last column: the next edge enters BLANK with col=0.
  assign boundary    = (state == S_DWELL) && (cnt == DWELL_LAST) && (col == COL_LAST);
  assign accept      = frame_valid && !pending;
  assign frame_ready = !pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BLANK;
      cnt         <= '0;
      col         <= '0;
      frame_cnt   <= '0;
      active      <= {TOTAL_COLUMNS{BLANK_CODE}};
      shadow      <= {TOTAL_COLUMNS{BLANK_CODE}};
      pending     <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      frame_start <= boundary;

      case (state)
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= S_DWELL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DWELL: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            state <= S_BLANK;
            col   <= (col == COL_LAST) ? '0 : col + COLW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_BLANK;
      endcase

      if (boundary) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
      end

      // Swap and accept are exclusive: an accept needs pending=0, a swap needs pending=1.
      if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        shadow  <= frame_data;
        pending <= 1'b1;
      end
    end
  end

  assign active_code = active[4*col +: 4];

  glyph_lookup u_glyph_lookup (
    .code    (active_code),
    .pattern (glyph)
  );

  assign lit = (state == S_DWELL) && enable && !(blink_enable && (frame_cnt >= BLINK_START));

  always_comb begin
    column_n = '1;
    row_n    = '1;
    if (lit) begin
      column_n[col]   = 1'b0;
      row_n[GW-1:0]   = glyph[GW-1:0];
    end
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Randomized self-checking bench for matrix_column_scanner against a frame-position reference model.
module tb_matrix_column_scanner;

  localparam int TC     = 4;
  localparam int DW     = 4;
  localparam int BW     = 2;
  localparam int BF     = 2;
  localparam int CS     = 7;
  localparam int SLOT   = BW + DW;
  localparam int PERIOD = TC * SLOT;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4*TC-1:0] frame_data = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic          enable = 1'b1;
  logic          blink_enable = 1'b0;
  logic [CS-1:0] row_n;
  logic [TC-1:0] column_n;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset plus the two glyph buffers.
  int unsigned t = 0;
  logic [3:0]  m_active [TC];
  logic [3:0]  m_shadow [TC];
  bit          m_pending = 0;
  bit          m_valid = 0;

  logic [6:0] ref_glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  always #5 clk = ~clk;

  matrix_column_scanner #(
    .COLUMN_SIZE   (CS),
    .TOTAL_COLUMNS (TC),
    .DWELL_CYCLES  (DW),
    .BLANK_CYCLES  (BW),
    .BLINK_FRAMES  (BF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .enable       (enable),
    .blink_enable (blink_enable),
    .row_n        (row_n),
    .column_n     (column_n),
    .frame_start  (frame_start)
  );

  // Compare outputs to the model, then advance one clock and return at the falling edge.
  task automatic cycle();
    int        p;
    int        c;
    bit        lit;
    bit        boundary;
    logic [6:0] exp_row;
    logic [3:0] exp_col;
    logic       exp_fs;
    logic       exp_rdy;
    #1;
    if (m_valid) begin
      p   = int'(t % PERIOD);
      c   = p / SLOT;
      lit = ((p % SLOT) >= BW) && enable &&
            !(blink_enable && (((t / PERIOD) % (2 * BF)) >= BF));
      exp_col = 4'hF;
      exp_row = 7'h7F;
      if (lit) begin
        exp_col[c] = 1'b0;
        exp_row    = ref_glyph[m_active[c]];
      end
      exp_fs  = (p == 0);
      exp_rdy = !m_pending;
      checks += 4;
      if (column_n !== exp_col) begin
        errors++;
        $display("FAIL column_n t=%0d got=%b exp=%b", t, column_n, exp_col);
      end
      if (row_n !== exp_row) begin
        errors++;
        $display("FAIL row_n t=%0d got=%b exp=%b", t, row_n, exp_row);
      end
      if (frame_start !== exp_fs) begin
        errors++;
        $display("FAIL frame_start t=%0d got=%b exp=%b", t, frame_start, exp_fs);
      end
      if (frame_ready !== exp_rdy) begin
        errors++;
        $display("FAIL frame_ready t=%0d got=%b exp=%b", t, frame_ready, exp_rdy);
      end
    end
    @(posedge clk);
    if (reset) begin
      t = 0;
      for (int i = 0; i < TC; i++) begin
        m_active[i] = 4'hF;
        m_shadow[i] = 4'hF;
      end
      m_pending = 0;
      m_valid   = 1;
    end else if (m_valid) begin
      boundary = (t % PERIOD) == PERIOD - 1;
      if (boundary && m_pending) begin
        for (int i = 0; i < TC; i++) m_active[i] = m_shadow[i];
        m_pending = 0;
      end else if (frame_valid && !m_pending) begin
        for (int i = 0; i < TC; i++) m_shadow[i] = frame_data[4*i +: 4];
        m_pending = 1;
      end
      t++;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < PERIOD && int'(t % PERIOD) != pos; i++) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    checks += 3;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_frame_start got=%b exp=1", frame_start);
    end
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_frame_ready got=%b exp=1", frame_ready);
    end
    if ({row_n, column_n} !== {7'h7F, 4'hF}) begin
      errors++;
      $display("FAIL reset_outputs got=%b/%b exp=1111111/1111", row_n, column_n);
    end
    run(2 * PERIOD);
  endtask

  task automatic test_double_buffer();
    bit got;
    run_to(10);
    frame_data  = 16'h3210;
    frame_valid = 1'b1;
    cycle();
    frame_data = 16'h9999;
    got = 0;
    for (int i = 0; i < 2 * PERIOD && !got; i++) begin
      if (!m_pending) got = 1;
      cycle();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL second_accept got=timeout exp=accepted");
    end
    frame_valid = 1'b0;
    run_to(0);
    run_to(8);
    #1;
    checks += 2;
    if (column_n !== 4'b1101) begin
      errors++;
      $display("FAIL col1_select got=%b exp=1101", column_n);
    end
    if (row_n !== 7'b0010000) begin
      errors++;
      $display("FAIL col1_glyph9 got=%b exp=0010000", row_n);
    end
    run(2 * PERIOD);
  endtask

  task automatic test_first_swap();
    frame_data  = 16'h3210;
    frame_valid = 1'b1;
    run_to(12);
    frame_valid = 1'b0;
    run_to(0);
    run_to(8);
    #1;
    checks++;
    if (row_n !== 7'b1111001) begin
      errors++;
      $display("FAIL col1_glyph1 got=%b exp=1111001", row_n);
    end
    run(PERIOD);
  endtask

  task automatic test_blink();
    blink_enable = 1'b1;
    run(8 * PERIOD);
    blink_enable = 1'b0;
  endtask

  task automatic test_enable_gap();
    run_to(3);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(PERIOD + 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      frame_valid = ($urandom % 4) == 0;
      frame_data  = 16'($urandom);
      enable      = ($urandom % 8) != 0;
      if (i % 50 == 0) blink_enable = $urandom % 2;
      cycle();
    end
    frame_valid  = 1'b0;
    enable       = 1'b1;
    blink_enable = 1'b0;
  endtask

  task automatic test_reset_pending();
    run_to(0);
    frame_data  = 16'h5678;
    frame_valid = 1'b1;
    cycle();
    frame_valid = 1'b0;
    run_to(10);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(2 * PERIOD);
  endtask

  initial begin
    test_reset();
    test_first_swap();
    test_double_buffer();
    test_blink();
    test_enable_gap();
    test_random();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
